// File: rtl/flag_unit.sv
// ---------------------------------------------------------------------------
// flag_unit -- producer side of the branch condition flags.
//
// Holds the architectural flag register {Z, V, N} consumed by the next-PC
// logic. Z and N are derived from the EX-stage ALU result, and V comes from
// the ALU overflow. Each bit is written under the EX opcode write mask.
//
// The unit also detects a flag read-after-write hazard between a conditional
// branch in ID and a flag-writing instruction in EX. On such a hazard it
// raises a one-cycle stall to the pipeline control.
//
// Optional feature (macro FLAG_STALL_CNT_EN):
//   defined   : stall_cnt counts unfrozen stall cycles and saturates at
//               all-ones.
//   undefined : stall_cnt is tied to zero and no counter flops exist.
//
// Parameters:
//   DW           ALU result width
//   STALL_CNT_W  width of the optional stall counter
//
// Ports:
//   clk           in   system clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   freeze        in   global pipeline hold; all state holds
//   ex_valid      in   EX instruction is live
//   ex_flag_mask  in   flags written by EX instruction, {Z,V,N}
//   ex_result     in   ALU result of EX instruction
//   ex_ovf        in   ALU signed overflow of EX instruction
//   id_valid      in   ID instruction is live
//   id_branch     in   ID instruction is a conditional branch
//   id_ccc        in   branch condition code of ID instruction
//   flags         out  registered flag register {Z,V,N}
//   stall         out  hold PC and IF/ID, bubble into EX
//   stall_cnt     out  stall cycle count (optional feature)
// ---------------------------------------------------------------------------
module flag_unit #(
  parameter int DW          = 16,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   freeze,
  input  logic                   ex_valid,
  input  logic [2:0]             ex_flag_mask,
  input  logic [DW-1:0]          ex_result,
  input  logic                   ex_ovf,
  input  logic                   id_valid,
  input  logic                   id_branch,
  input  logic [2:0]             id_ccc,
  output logic [2:0]             flags,
  output logic                   stall,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] flags_q, flags_d;
  logic [2:0] new_flags;
  logic [2:0] need;
  logic       hz;

  // New flag values from the EX instruction, in {Z,V,N} order.
  assign new_flags = {(ex_result == '0), ex_ovf, ex_result[DW-1]};

  // Flags each branch condition code reads.
  always_comb begin
    need = 3'b000;
    case (id_ccc)
      3'b000:  need = 3'b100;
      3'b001:  need = 3'b100;
      3'b010:  need = 3'b101;
      3'b011:  need = 3'b001;
      3'b100:  need = 3'b101;
      3'b101:  need = 3'b101;
      3'b110:  need = 3'b010;
      default: need = 3'b000;
    endcase
  end

  assign hz = id_valid & id_branch & ex_valid & (|(need & ex_flag_mask));

  // Per-bit masked update. Killed or bubble EX slots (ex_valid=0) never write.
  always_comb begin
    flags_d = flags_q;
    if (ex_valid && !freeze) begin
      for (int i = 0; i < 3; i++) begin
        if (ex_flag_mask[i]) flags_d[i] = new_flags[i];
      end
    end
  end

  // HOLD covers the cycle after an unfrozen stall. The bubble is then in EX,
  // and the producer's flags are already registered, so the branch may proceed.
  // A frozen stall stays in RUN so that the stall remains asserted.
  // The stall is also gated with rst_n. This keeps the stall low while reset
  // is asserted, even if hazard inputs are present.
  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    case (state_q)
      RUN: begin
        stall = hz & rst_n;
        if (hz && !freeze) state_d = HOLD;
      end
      HOLD: begin
        if (!freeze) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      flags_q <= 3'b000;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
    end
  end

  assign flags = flags_q;

`ifdef FLAG_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Count only stall cycles that actually advance the pipeline.
  // Saturate at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && !freeze && (stall_cnt_q != {STALL_CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: doc/flag_unit.md
Name: flag_unit

Overview:
- Producer side of the branch condition flags.
- Holds the architectural flag register F[2:0] = {Z, V, N}, which the next-PC logic consumes.
- Computes Z and N from the EX-stage ALU result and takes V from the ALU overflow output, then updates per-bit under an opcode write mask.
- Detects flag read-after-write hazards between a conditional branch in ID and a flag-writing instruction in EX, and drives a one-cycle stall to the pipeline control.

Parameters:
- DW, 16, ALU result width.
- STALL_CNT_W, 16, width of the optional stall counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst_n  input  1  asynchronous active-low reset
- freeze  input  1  global pipeline hold (memory wait); all state holds
- ex_valid  input  1  EX-stage instruction is live (not a bubble, not flushed)
- ex_flag_mask  input  3  flags written by the EX instruction, {Z,V,N} bit order
- ex_result  input  DW  ALU result of the EX instruction
- ex_ovf  input  1  ALU signed overflow of the EX instruction
- id_valid  input  1  ID-stage instruction is live
- id_branch  input  1  ID instruction is a conditional branch (B or BR)
- id_ccc  input  3  branch condition code of the ID instruction
- flags  output  3  registered flag register {Z,V,N}, to next-PC logic
- stall  output  1  hold PC and IF/ID; insert a bubble into EX
- stall_cnt  output  STALL_CNT_W  stall cycle count (only with the optional feature)

Behaviour:
- Reset (async, rst_n=0):
  - flags=3'b000, FSM=RUN, stall=0, stall_cnt=0.
  - Takes effect immediately, including mid-stall.
- Flag computation (combinational, EX):
  - z_new = (ex_result == 0).
  - n_new = ex_result[DW-1].
  - v_new = ex_ovf.
- Flag register:
  - On a clock edge with ex_valid=1 and freeze=0, each bit i with ex_flag_mask[i]=1 loads its new value. Bits with a mask of 0 hold.
  - ex_valid=0 or freeze=1 holds all bits.
  - Latency: flags reflect an EX instruction one cycle after it is in EX.
- Needed-flag mask from id_ccc, {Z,V,N} order:
  - 000 -> 100
  - 001 -> 100
  - 010 -> 101
  - 011 -> 001
  - 100 -> 101
  - 101 -> 101
  - 110 -> 010
  - 111 -> 000 (unconditional)
- Hazard:
  - hz = id_valid & id_branch & ex_valid & |(need & ex_flag_mask).
  - No hazard if the masks are disjoint.
- FSM (two states, RUN and HOLD):
  - RUN: stall = hz.
    - If hz & ~freeze -> HOLD.
    - If hz & freeze -> stay in RUN, with stall held at 1.
  - HOLD: stall = 0, because the bubble now in EX has ex_valid=0 and flags now hold the producer's result.
    - If ~freeze -> RUN.
    - If freeze -> stay in HOLD.
  - A branch therefore never stalls more than one non-frozen cycle per producer.
  - Back-to-back: a new hazard in the cycle after HOLD stalls again.
- stall is combinational from the state and the inputs. flags is purely registered.
- Flush: the pipeline deasserts id_valid/ex_valid for killed instructions. A killed EX instruction never updates flags, and a killed ID branch never stalls.

Optional Feature:
- Macro: FLAG_STALL_CNT_EN.
- Defined:
  - stall_cnt increments by 1 on each clock edge where stall=1 and freeze=0.
  - Saturates at all-ones.
  - Reset clears it.
- Undefined:
  - stall_cnt is tied to 0.
  - No counter flops exist.

Test Plan:
- Reset with rst_n=0 during HOLD -> flags=000, stall=0, and the FSM returns to RUN immediately, without waiting for a clock edge.
- EX: ex_valid=1, mask=111, result=16'h0000, ovf=0 -> flags=100 next cycle. Then result=16'h8000, ovf=1, mask=011 -> flags=111 (Z held).
- ID branch with ccc=000, EX mask=100 -> stall=1 for exactly 1 cycle. The next cycle, with a bubble in EX, gives stall=0 and flags updated. The FSM goes RUN->HOLD->RUN.
- ID branch with ccc=110 (needs V), EX mask=101 -> stall=0. ccc=111 with any mask -> stall=0.
- Hazard with freeze=1 for 3 cycles -> stall stays 1 and flags hold. The release gives one HOLD cycle, then RUN. With FLAG_STALL_CNT_EN, stall_cnt=1.
- ex_valid=0 with mask=111 and result=0 -> flags unchanged. With FLAG_STALL_CNT_EN, forcing the counter to 16'hFFFF and stalling again leaves it at 16'hFFFF.
